zone_spi_sched: RTL and testbench

- Collects the per-zone luminance averages produced by the zone-averaging datapath (24 zones per frame) into a ping-pong buffer.
- Once per frame, streams one packet to the SPI master byte interface: header, 24 zone bytes, XOR checksum.
- Sits between the zone-averaging block and the SPI master. Keeps zone capture and SPI transmission decoupled so capture never stalls.

---
 rtl/zone_spi_sched_if.sv | 31 +++
 rtl/zone_spi_sched.sv | 188 ++++++++++++++++++
 tb/tb_zone_spi_sched.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/zone_spi_sched_if.sv
// Bundles the zone-capture input and SPI byte-stream output of zone_spi_sched.
// The master modport is the environment side: the zone-averaging block plus the SPI master.
// The slave modport is the scheduler side.
interface zone_spi_sched_if #(
   parameter int DATA_W = 8
);
   // zone capture side
   logic              i_v_sync;
   logic              zone_de;
   logic [4:0]        zone_idx;
   logic [DATA_W-1:0] zone_data;
   // SPI master byte side
   logic              tx_valid;
   logic [DATA_W-1:0] tx_data;
   logic              tx_ready;
   logic              spi_cs_req;
   // status
   logic              busy;
   logic [7:0]        frame_cnt;
   logic [7:0]        drop_cnt;

   modport master (
      output i_v_sync, zone_de, zone_idx, zone_data, tx_ready,
      input  tx_valid, tx_data, spi_cs_req, busy, frame_cnt, drop_cnt
   );

   modport slave (
      input  i_v_sync, zone_de, zone_idx, zone_data, tx_ready,
      output tx_valid, tx_data, spi_cs_req, busy, frame_cnt, drop_cnt
   );
endinterface

// File: rtl/zone_spi_sched.sv
// Zone luminance packet scheduler.
// Captures per-zone averages into a ping-pong buffer. Once per frame it streams
// the following packet to the SPI master: HEADER, then NUM_ZONES zone bytes, then the XOR checksum.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no packet; waiting for a frame edge or a pending frame
// HDR   | presenting HEADER byte, CS requested
// DATA  | presenting read_bank[k], k = 0..NUM_ZONES-1
// CSUM  | presenting XOR of all zone bytes in the read bank
// DONE  | one cycle gap: CS released, frame_cnt incremented
module zone_spi_sched #(
   parameter int                    NUM_ZONES = 24,
   parameter int                    DATA_W    = 8,
   parameter logic [DATA_W-1:0]     HEADER    = 8'hA5
) (
   input logic                   clk,
   input logic                   rst_n,
   zone_spi_sched_if.slave       bus
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_HDR  = 3'd1,
      S_DATA = 3'd2,
      S_CSUM = 3'd3,
      S_DONE = 3'd4
   } state_t;

   state_t              state_q, state_d;
   logic                vs_d_q, vs_d_d;
   logic                pend_q, pend_d;
   logic                wr_bank_q, wr_bank_d;
   logic [4:0]          k_q, k_d;
   logic [DATA_W-1:0]   csum_q, csum_d;
   logic [7:0]          frame_cnt_q, frame_cnt_d;
   logic [7:0]          drop_cnt_q, drop_cnt_d;
   logic [DATA_W-1:0]   bank_q [2][NUM_ZONES];
   logic [DATA_W-1:0]   bank_d [2][NUM_ZONES];

   logic                vs_rise;
   logic                zone_wr;
   logic                start;
   logic                rd_bank;
   logic                tx_valid;
   logic [DATA_W-1:0]   tx_data;
   logic                cs_req;

   assign vs_d_d  = bus.i_v_sync;
   assign vs_rise = bus.i_v_sync & ~vs_d_q;
   assign zone_wr = bus.zone_de && (bus.zone_idx < 5'(NUM_ZONES));
   assign rd_bank = ~wr_bank_q;
   // A pending frame and a fresh edge both start a packet, but only from IDLE.
   assign start   = (state_q == S_IDLE) && (vs_rise || pend_q);

   // Bank write, swap and clear.
   // A capture in the swap cycle lands after the clear, so that capture is kept.
   always_comb begin
      bank_d    = bank_q;
      wr_bank_d = wr_bank_q;
      if (start) begin
         wr_bank_d = ~wr_bank_q;
         for (int i = 0; i < NUM_ZONES; i++) begin
            bank_d[rd_bank][i] = '0;
         end
      end
      if (zone_wr) begin
         bank_d[wr_bank_d][bus.zone_idx] = bus.zone_data;
      end
   end

   // Packet FSM, checksum accumulation, frame/drop accounting and byte outputs.
   always_comb begin
      state_d     = state_q;
      k_d         = k_q;
      csum_d      = csum_q;
      pend_d      = pend_q;
      frame_cnt_d = frame_cnt_q;
      drop_cnt_d  = drop_cnt_q;
      tx_valid    = 1'b0;
      tx_data     = '0;
      cs_req      = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_HDR;
               pend_d  = 1'b0;
               csum_d  = '0;
            end
         end
         S_HDR: begin
            tx_valid = 1'b1;
            tx_data  = HEADER;
            cs_req   = 1'b1;
            if (bus.tx_ready) begin
               state_d = S_DATA;
               k_d     = 5'd0;
            end
         end
         S_DATA: begin
            tx_valid = 1'b1;
            tx_data  = bank_q[rd_bank][k_q];
            cs_req   = 1'b1;
            if (bus.tx_ready) begin
               csum_d = csum_q ^ bank_q[rd_bank][k_q];
               if (k_q == 5'(NUM_ZONES - 1)) begin
                  state_d = S_CSUM;
               end else begin
                  k_d = k_q + 5'd1;
               end
            end
         end
         S_CSUM: begin
            tx_valid = 1'b1;
            tx_data  = csum_q;
            cs_req   = 1'b1;
            if (bus.tx_ready) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            frame_cnt_d = frame_cnt_q + 8'd1;
            state_d     = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Edges while a packet is in flight are held as one pending frame.
      // Any further edge while a frame is pending counts as a dropped frame.
      // The dropped frame's data is overwritten in the write bank.
      if (vs_rise && (state_q != S_IDLE)) begin
         if (pend_q) begin
            if (drop_cnt_q != 8'hFF) begin
               drop_cnt_d = drop_cnt_q + 8'd1;
            end
         end else begin
            pend_d = 1'b1;
         end
      end
   end

   // State and control registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         vs_d_q      <= 1'b0;
         pend_q      <= 1'b0;
         wr_bank_q   <= 1'b0;
         k_q         <= 5'd0;
         csum_q      <= '0;
         frame_cnt_q <= 8'd0;
         drop_cnt_q  <= 8'd0;
      end else begin
         state_q     <= state_d;
         vs_d_q      <= vs_d_d;
         pend_q      <= pend_d;
         wr_bank_q   <= wr_bank_d;
         k_q         <= k_d;
         csum_q      <= csum_d;
         frame_cnt_q <= frame_cnt_d;
         drop_cnt_q  <= drop_cnt_d;
      end
   end

   // Ping-pong zone storage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < NUM_ZONES; i++) begin
               bank_q[b][i] <= '0;
            end
         end
      end else begin
         bank_q <= bank_d;
      end
   end

   assign bus.tx_valid   = tx_valid;
   assign bus.tx_data    = tx_data;
   assign bus.spi_cs_req = cs_req;
   assign bus.busy       = (state_q != S_IDLE);
   assign bus.frame_cnt  = frame_cnt_q;
   assign bus.drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_zone_spi_sched.sv
// Bench for zone_spi_sched: directed scenarios plus a random phase.
// The outputs are checked against a packet-level reference model.
module tb_zone_spi_sched;
   localparam int NZ = 24;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   zone_spi_sched_if #(.DATA_W(8)) bus ();

   zone_spi_sched #(.NUM_ZONES(NZ), .DATA_W(8), .HEADER(8'hA5)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // The model keeps the capture frame and a queue of expected bytes.
   // It also counts the bytes still owed in the current packet and tracks the one-cycle gap after each packet.
   logic [7:0] m_wr [NZ];
   logic [7:0] m_q [$];
   int         m_left;
   bit         m_done, m_pend, m_vs_prev;
   int         m_frame, m_drop;
   bit         vsr, busy_m, hs_m, start_m;
   logic [7:0] xs;

   always @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NZ; i++) m_wr[i] = 8'h00;
         m_q.delete();
         m_left = 0; m_done = 0; m_pend = 0; m_vs_prev = 0;
         m_frame = 0; m_drop = 0;
      end else begin
         vsr       = bus.i_v_sync && !m_vs_prev;
         m_vs_prev = bus.i_v_sync;
         busy_m    = (m_left > 0) || m_done;
         hs_m      = (m_left > 0) && bus.tx_ready;
         start_m   = !busy_m && (vsr || m_pend);
         if (start_m) begin
            xs = 8'h00;
            m_q.push_back(8'hA5);
            for (int i = 0; i < NZ; i++) begin
               m_q.push_back(m_wr[i]);
               xs ^= m_wr[i];
               m_wr[i] = 8'h00;
            end
            m_q.push_back(xs);
            m_left = NZ + 2;
            m_pend = 0;
         end else if (vsr && busy_m) begin
            if (m_pend) m_drop = (m_drop < 255) ? m_drop + 1 : 255;
            else        m_pend = 1;
         end
         if (bus.zone_de && int'(bus.zone_idx) < NZ) m_wr[bus.zone_idx] = bus.zone_data;
         if (hs_m) begin
            void'(m_q.pop_front());
            m_left--;
            if (m_left == 0) m_done = 1;
         end else if (m_done) begin
            m_done  = 0;
            m_frame = (m_frame + 1) % 256;
         end
      end
   end

   // ---------------- per-cycle checking and monitors ----------------
   int         cs_run = 0, last_run = 0;
   logic [7:0] last_byte = 8'h00;

   always @(negedge clk) begin
      if (!rst_n) begin
         cs_run = 0;
      end else begin
         if (chk_en) begin
            check("tx_valid", 32'(bus.tx_valid), 32'(m_left > 0));
            check("spi_cs_req", 32'(bus.spi_cs_req), 32'(m_left > 0));
            check("busy", 32'(bus.busy), 32'((m_left > 0) || m_done));
            if (m_left > 0 && m_q.size() > 0) check("tx_data", 32'(bus.tx_data), 32'(m_q[0]));
            check("frame_cnt", 32'(bus.frame_cnt), 32'(m_frame));
            check("drop_cnt", 32'(bus.drop_cnt), 32'(m_drop));
         end
         if (bus.tx_valid && bus.tx_ready) last_byte = bus.tx_data;
         if (bus.spi_cs_req) cs_run++;
         else if (cs_run > 0) begin
            last_run = cs_run;
            cs_run   = 0;
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr_zone(input logic [4:0] idx, input logic [7:0] d);
      bus.zone_de   = 1'b1;
      bus.zone_idx  = idx;
      bus.zone_data = d;
      tick();
      bus.zone_de   = 1'b0;
   endtask

   task automatic pulse_vs();
      bus.i_v_sync = 1'b1;
      tick();
      bus.i_v_sync = 1'b0;
   endtask

   // rmode 0: ready held high, 1: ready one cycle in three, 2: random ready
   task automatic wait_idle(input int rmode, input string tag);
      bit ok = 1'b0;
      for (int i = 0; i < 600; i++) begin
         if (m_left == 0 && !m_done && !m_pend && m_q.size() == 0) begin
            ok = 1'b1;
            break;
         end
         case (rmode)
            0:       bus.tx_ready = 1'b1;
            1:       bus.tx_ready = (i % 3 == 0);
            default: bus.tx_ready = ($urandom_range(0, 1) == 1);
         endcase
         tick();
      end
      bus.tx_ready = 1'b1;
      if (!ok) check({tag, "_timeout"}, 32'd1, 32'd0);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      bus.i_v_sync  = 1'b0;
      bus.zone_de   = 1'b0;
      bus.zone_idx  = 5'd0;
      bus.zone_data = 8'h00;
      bus.tx_ready  = 1'b0;
      repeat (3) tick();
      check("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
      check("rst_tx_data", 32'(bus.tx_data), 32'd0);
      check("rst_cs", 32'(bus.spi_cs_req), 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_frame", 32'(bus.frame_cnt), 32'd0);
      check("rst_drop", 32'(bus.drop_cnt), 32'd0);
      rst_n  = 1'b1;
      chk_en = 1'b1;
      tick();

      // 1: full frame, ready held high
      for (int i = 0; i < NZ; i++) wr_zone(5'(i), 8'(i + 1));
      bus.tx_ready = 1'b1;
      bus.i_v_sync = 1'b1;
      @(negedge clk);
      check("s1_lat_edge", 32'(bus.tx_valid), 32'd0);
      @(posedge clk); #1;
      bus.i_v_sync = 1'b0;
      @(negedge clk);
      check("s1_lat_next", 32'(bus.tx_valid), 32'd1);
      check("s1_hdr", 32'(bus.tx_data), 32'hA5);
      #1;
      wait_idle(0, "s1");
      check("s1_cs_len", 32'(last_run), 32'd26);
      check("s1_csum", 32'(last_byte), 32'h18);
      check("s1_frames", 32'(bus.frame_cnt), 32'd1);

      // 2: single zone
      wr_zone(5'd5, 8'h7F);
      pulse_vs();
      wait_idle(0, "s2");
      check("s2_csum", 32'(last_byte), 32'h7F);

      // 3: ready one cycle in three
      for (int i = 0; i < NZ; i++) wr_zone(5'(i), 8'(i + 1));
      pulse_vs();
      wait_idle(1, "s3");
      check("s3_csum", 32'(last_byte), 32'h18);
      check("s3_frames", 32'(bus.frame_cnt), 32'd3);

      // 4: two further edges while a packet is stalled
      bus.tx_ready = 1'b0;
      for (int i = 0; i < NZ; i++) wr_zone(5'(i), 8'(8'h10 + i));
      pulse_vs();
      for (int i = 0; i < NZ; i++) wr_zone(5'(i), 8'(8'h40 + i));
      pulse_vs();
      for (int i = 0; i < NZ; i++) wr_zone(5'(i), 8'(8'h80 + i * 3));
      pulse_vs();
      tick();
      check("s4_drop_held", 32'(bus.drop_cnt), 32'd1);
      wait_idle(0, "s4");
      check("s4_drop", 32'(bus.drop_cnt), 32'd1);
      check("s4_frames", 32'(bus.frame_cnt), 32'd5);

      // 5: out-of-range index ignored
      wr_zone(5'd25, 8'hFF);
      wr_zone(5'd2, 8'h33);
      pulse_vs();
      wait_idle(0, "s5");
      check("s5_csum", 32'(last_byte), 32'h33);

      // random phase
      for (int c = 0; c < 3000; c++) begin
         bus.zone_de   = ($urandom_range(0, 1) == 1);
         bus.zone_idx  = 5'($urandom_range(0, 31));
         bus.zone_data = 8'($urandom);
         bus.tx_ready  = ($urandom_range(0, 3) != 0);
         bus.i_v_sync  = ($urandom_range(0, 29) == 0);
         tick();
      end
      bus.zone_de  = 1'b0;
      bus.i_v_sync = 1'b0;
      tick();
      wait_idle(2, "rnd");

      // reset during the 10th data byte
      for (int i = 0; i < NZ; i++) wr_zone(5'(i), 8'($urandom));
      pulse_vs();
      begin
         bit hit = 1'b0;
         for (int i = 0; i < 100; i++) begin
            if (m_left == 16) begin
               hit = 1'b1;
               break;
            end
            tick();
         end
         if (!hit) check("rst_reach_timeout", 32'd1, 32'd0);
      end
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_tx_valid", 32'(bus.tx_valid), 32'd0);
      check("arst_cs", 32'(bus.spi_cs_req), 32'd0);
      check("arst_busy", 32'(bus.busy), 32'd0);
      check("arst_frame", 32'(bus.frame_cnt), 32'd0);
      check("arst_drop", 32'(bus.drop_cnt), 32'd0);
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
      pulse_vs();
      @(negedge clk);
      check("post_rst_hdr", 32'(bus.tx_data), 32'hA5);
      #1;
      wait_idle(0, "post_rst");
      check("post_rst_csum", 32'(last_byte), 32'h00);
      check("post_rst_frames", 32'(bus.frame_cnt), 32'd1);
      check("post_rst_len", 32'(last_run), 32'd26);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
